// File: rtl/bus_sequencer_if.sv
// Request/response and external memory bus signals of the bus sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface bus_sequencer_if #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
);
  localparam int LEN_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic              Req;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [LEN_W-1:0]  ReqLen;
  logic              Abort;
  logic [DATA_W-1:0] WrData;
  logic              WrAck;
  logic [DATA_W-1:0] RdData;
  logic              RdValid;
  logic              Busy;
  logic              Done;
  logic              Aborted;
  logic [ADDR_W-1:0] BusAddr;
  logic [DATA_W-1:0] BusDataOut;
  logic [DATA_W-1:0] BusDataIn;
  logic              nWait;
  logic              ALE;
  logic              nME;
  logic              nOE;
  logic              nWE;
  logic              ENB;
  logic              MemEn;

  modport master (
    input  Req, ReqWrite, ReqAddr, ReqLen, Abort, WrData, BusDataIn, nWait,
    output WrAck, RdData, RdValid, Busy, Done, Aborted, BusAddr, BusDataOut,
           ALE, nME, nOE, nWE, ENB, MemEn
  );

  modport slave (
    output Req, ReqWrite, ReqAddr, ReqLen, Abort, WrData, BusDataIn, nWait,
    input  WrAck, RdData, RdValid, Busy, Done, Aborted, BusAddr, BusDataOut,
           ALE, nME, nOE, nWE, ENB, MemEn
  );
endinterface

// File: rtl/bus_sequencer.sv
// Burst bus sequencer: turns a read/write request into ALE/nME/nOE/nWE beats
// with fixed wait states, nWait extension, address increment and abort.
module bus_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic            Clock,
  input  logic            nReset,
  bus_sequencer_if.master bus
);
  localparam int LEN_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  typedef enum logic [2:0] {IDLE, ADDR, ACCESS, STROBE, HOLD} state_t;

  state_t            state_reg, state_next;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [3:0]        wait_cnt_reg;
  logic              abort_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              abort_eff;
  logic              end_burst;

  // An abort raised in the HOLD cycle itself still ends the burst there.
  assign abort_eff = abort_reg | bus.Abort;
  assign end_burst = (len_reg == '0) || abort_eff;

  assign bus.Busy       = (state_reg != IDLE);
  assign bus.BusAddr    = addr_reg;
  assign bus.BusDataOut = wr_data_reg;
  assign bus.RdData     = rd_data_reg;

  always_comb begin
    state_next  = state_reg;
    bus.ALE     = 1'b0;
    bus.nME     = 1'b1;
    bus.nOE     = 1'b1;
    bus.nWE     = 1'b1;
    bus.ENB     = 1'b0;
    bus.MemEn   = 1'b0;
    bus.WrAck   = 1'b0;
    bus.RdValid = 1'b0;
    bus.Done    = 1'b0;
    bus.Aborted = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.Req) state_next = ADDR;
      end
      ADDR: begin
        bus.ALE    = 1'b1;
        bus.WrAck  = write_reg;
        state_next = ACCESS;
      end
      ACCESS: begin
        bus.nME   = 1'b0;
        bus.nOE   = write_reg;
        bus.nWE   = ~write_reg;
        bus.MemEn = write_reg;
        // nWait only matters once the fixed wait states have elapsed
        if (wait_cnt_reg == WAIT_LAST && bus.nWait) state_next = STROBE;
      end
      STROBE: begin
        bus.nME    = 1'b0;
        bus.nOE    = write_reg;
        bus.ENB    = ~write_reg;
        bus.MemEn  = write_reg;
        state_next = HOLD;
      end
      HOLD: begin
        bus.MemEn   = write_reg;
        bus.RdValid = ~write_reg;
        if (end_burst) begin
          bus.Done    = 1'b1;
          bus.Aborted = abort_eff;
          state_next  = IDLE;
        end else begin
          state_next = ADDR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg    <= IDLE;
      write_reg    <= 1'b0;
      addr_reg     <= '0;
      len_reg      <= '0;
      wait_cnt_reg <= '0;
      abort_reg    <= 1'b0;
      wr_data_reg  <= '0;
      rd_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.Req) begin
            write_reg <= bus.ReqWrite;
            addr_reg  <= bus.ReqAddr;
            len_reg   <= bus.ReqLen;
          end
        end
        ADDR: begin
          wait_cnt_reg <= '0;
          if (write_reg) wr_data_reg <= bus.WrData;
        end
        ACCESS: begin
          if (wait_cnt_reg != WAIT_LAST) wait_cnt_reg <= wait_cnt_reg + 4'd1;
        end
        STROBE: begin
          if (!write_reg) rd_data_reg <= bus.BusDataIn;
        end
        HOLD: begin
          if (!end_burst) begin
            addr_reg <= addr_reg + ADDR_W'(1);
            len_reg  <= len_reg - LEN_W'(1);
          end
        end
        default: ;
      endcase
      if (state_next == IDLE)
        abort_reg <= 1'b0;
      else if (state_reg != IDLE && bus.Abort)
        abort_reg <= 1'b1;
    end
  end
endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter WAIT_STATES, default 1, fixed extra access cycles per beat (0..15).
REQ-004 SHALL have parameter MAX_BURST, default 4, maximum beats per request (power of two, >=1); LEN_W = max(1, clog2(MAX_BURST)).
REQ-005 SHALL have the following ports:
- Clock  in  1  clock; all state changes on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Req  in  1  transfer request, sampled in IDLE only.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddr  in  ADDR_W  start address.
- ReqLen  in  LEN_W  beats minus one.
- Abort  in  1  end burst after current beat.
- WrData  in  DATA_W  write data for current beat.
- WrAck  out  1  WrData consumed this cycle.
- RdData  out  DATA_W  captured read data.
- RdValid  out  1  RdData valid this cycle.
- Busy  out  1  transfer in progress.
- Done  out  1  one-cycle completion pulse.
- Aborted  out  1  qualifies Done: burst cut short.
- BusAddr  out  ADDR_W  address to latch.
- BusDataOut  out  DATA_W  write data to pads.
- BusDataIn  in  DATA_W  read data from pads.
- nWait  in  1  external wait, active-low.
- ALE  out  1  address latch enable.
- nME  out  1  memory enable, active-low.
- nOE  out  1  output enable, active-low.
- nWE  out  1  write enable, active-low.
- ENB  out  1  read data buffer enable.
- MemEn  out  1  pad output drive enable.

Function
REQ-006 SHALL implement states IDLE, ADDR, ACCESS, STROBE, HOLD; only IDLE has Busy=0.
REQ-007 In IDLE, Req=1 at an edge SHALL latch ReqWrite, ReqAddr, ReqLen and move to ADDR; Req during Busy SHALL be ignored.
REQ-008 ADDR (1 cycle) SHALL drive ALE=1, nME=1, nOE=1, nWE=1, BusAddr = current address; for writes, WrAck=1 and WrData SHALL be registered into BusDataOut.
REQ-009 ACCESS SHALL drive nME=0; reads: nOE=0, nWE=1, MemEn=0; writes: nWE=0, nOE=1, MemEn=1. It lasts 1+WAIT_STATES cycles, then extends while nWait=0, sampled only in the final counted cycle and in each extension cycle.
REQ-010 STROBE (1 cycle) SHALL keep nME=0; reads: ENB=1, nOE=0, RdData <= BusDataIn at the end of the cycle; writes: nWE=1, MemEn=1.
REQ-011 HOLD (1 cycle) SHALL drive nME=1, nOE=1, nWE=1; writes: MemEn=1, BusDataOut held; reads: RdValid=1.
REQ-012 Beat latency SHALL be 4+WAIT_STATES cycles with no nWait extension.
REQ-013 After HOLD: if beats remain and no abort is pending, the address SHALL increment by 1 (modulo 2^ADDR_W, wraps silently) and the FSM SHALL go to ADDR; otherwise it SHALL go to IDLE with Done=1 for that HOLD cycle.
REQ-014 Abort=1 in any Busy cycle SHALL set a pending flag; the current beat SHALL complete, then the FSM SHALL end with Done=1, Aborted=1. Abort during the last beat SHALL still set Aborted=1. Abort in IDLE SHALL be ignored.
REQ-015 Simultaneous Done and Req SHALL not start a new transfer; Req is accepted on the next IDLE cycle.
REQ-016 Outside the states named above, ALE, ENB, MemEn, WrAck, RdValid, Done and Aborted SHALL be 0, and nME, nOE, nWE SHALL be 1.

Reset
REQ-017 nReset=0 SHALL immediately (asynchronously) force IDLE and set ALE=0, nME=1, nOE=1, nWE=1, ENB=0, MemEn=0, Busy=0, Done=0, Aborted=0, WrAck=0, RdValid=0, BusAddr=0, BusDataOut=0, RdData=0, and clear the beat counter and abort flag, including mid-burst.

Verification
REQ-018 Single read, WAIT_STATES=1, ReqAddr=0x0100, BusDataIn=0xBEEF, nWait=1 -> ALE at cycle 1, nME low for cycles 2-4, ENB at cycle 4, RdValid with RdData=0xBEEF and Done at cycle 5.
REQ-019 Write burst ReqLen=3 at 0xFFFE, WrData 0x11,0x22,0x33,0x44 -> BusAddr 0xFFFE, 0xFFFF, 0x0000, 0x0001; four WrAck pulses; MemEn high from ACCESS through HOLD of each beat; one Done after 20 cycles.
REQ-020 nWait held low for 3 cycles during a read ACCESS -> beat lengthens by exactly 3 cycles; nME stays low throughout.
REQ-021 Abort pulsed during beat 1 of a 4-beat read -> beat 1 completes; Done=1 and Aborted=1 in beat 1 HOLD; 2 RdValid pulses total.
REQ-022 nReset asserted during a write ACCESS -> same-cycle nWE=1, nME=1, MemEn=0, Busy=0; a new Req after release starts a clean burst.
